// File: rtl/mux_arb_pkg.sv
// Shared constants and helpers for the arbitrated N:1 val/rdy mux.
// Arbitration mode encodings plus the select-width helper.
package mux_arb_pkg;

   localparam int ARB_FIXED = 0;
   localparam int ARB_RR    = 1;

   // Width of a channel index; a 2-input mux still needs one select bit.
   function automatic int sel_bits(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/mux_arb_nb_rtl_if.sv
// Producer-side and consumer-side handshake bundle of the arbitrated mux.
// The master modport is the environment, the slave modport is the mux itself.
interface mux_arb_nb_rtl_if import mux_arb_pkg::*; #(
   parameter int NBITS   = 4,
   parameter int NINPUTS = 4,
   parameter int SELBITS = sel_bits(NINPUTS)
);

   logic [NINPUTS-1:0]       in_val;
   logic [NINPUTS-1:0]       in_rdy;
   logic [NINPUTS*NBITS-1:0] in_data;
   logic                     out_val;
   logic                     out_rdy;
   logic [NBITS-1:0]         out_data;
   logic [SELBITS-1:0]       out_sel;

   modport master (
      output in_val, in_data, out_rdy,
      input  in_rdy, out_val, out_data, out_sel
   );

   modport slave (
      input  in_val, in_data, out_rdy,
      output in_rdy, out_val, out_data, out_sel
   );

endinterface

// File: rtl/arb_rr_nb_rtl.sv
// Combinational grant: first requester scanning from ptr (round-robin) or from 0 (fixed).
// No state; one-hot and binary grant are produced together for the mux and pointer logic.
module arb_rr_nb_rtl import mux_arb_pkg::*; #(
   parameter int NINPUTS = 4,
   parameter int SELBITS = sel_bits(NINPUTS)
) (
   input  logic [NINPUTS-1:0] req_i,
   input  logic [SELBITS-1:0] ptr_i,
   input  logic               mode_i,
   output logic [NINPUTS-1:0] gnt_oh_o,
   output logic [SELBITS-1:0] gnt_idx_o,
   output logic               gnt_vld_o
);

   always_comb begin
      int  base;
      int  idx;
      logic found;
      base      = 0;
      idx       = 0;
      found     = 1'b0;
      gnt_oh_o  = '0;
      gnt_idx_o = '0;
      // An out-of-range pointer falls back to index 0 so the grant stays below NINPUTS.
      if (mode_i && (int'(ptr_i) < NINPUTS)) begin
         base = int'(ptr_i);
      end
      for (int k = 0; k < NINPUTS; k++) begin
         idx = base + k;
         if (idx >= NINPUTS) begin
            idx = idx - NINPUTS;
         end
         if (!found && req_i[idx]) begin
            found         = 1'b1;
            gnt_oh_o[idx] = 1'b1;
            gnt_idx_o     = idx[SELBITS-1:0];
         end
      end
      gnt_vld_o = found;
   end

endmodule

// File: rtl/mux_arb_nb_rtl.sv
// Arbitrated N:1 val/rdy mux feeding a single-entry registered output buffer.
// One-cycle latency, one transfer per cycle; out_rdy reaches in_rdy combinationally.
module mux_arb_nb_rtl import mux_arb_pkg::*; #(
   parameter int NBITS    = 4,
   parameter int NINPUTS  = 4,
   parameter int ARB_MODE = ARB_RR
) (
   input  logic              clk,
   input  logic              rst_n,
   mux_arb_nb_rtl_if.slave   bus
);

   localparam int SELBITS = sel_bits(NINPUTS);

   logic [SELBITS-1:0] ptr_q, ptr_d;
   logic               out_val_q, out_val_d;
   logic [NBITS-1:0]   out_data_q, out_data_d;
   logic [SELBITS-1:0] out_sel_q, out_sel_d;

   logic [NINPUTS-1:0] gnt_oh;
   logic [SELBITS-1:0] gnt_idx;
   logic               gnt_vld;
   logic [NBITS-1:0]   gnt_data;
   logic               can_accept;
   logic               in_xfer;
   logic               out_xfer;

   arb_rr_nb_rtl #(
      .NINPUTS (NINPUTS),
      .SELBITS (SELBITS)
   ) u_arb (
      .req_i     (bus.in_val),
      .ptr_i     (ptr_q),
      .mode_i    (ARB_MODE == ARB_RR),
      .gnt_oh_o  (gnt_oh),
      .gnt_idx_o (gnt_idx),
      .gnt_vld_o (gnt_vld)
   );

   always_comb begin
      gnt_data = '0;
      for (int i = 0; i < NINPUTS; i++) begin
         if (gnt_oh[i]) begin
            gnt_data = bus.in_data[i*NBITS +: NBITS];
         end
      end
   end

   // Holding rst_n low blocks every handshake so nothing is accepted during reset.
   assign can_accept = rst_n && (!out_val_q || bus.out_rdy);
   assign in_xfer    = can_accept && gnt_vld;
   assign out_xfer   = out_val_q && bus.out_rdy;
   assign bus.in_rdy = can_accept ? gnt_oh : '0;

   always_comb begin
      ptr_d      = ptr_q;
      out_val_d  = out_val_q;
      out_data_d = out_data_q;
      out_sel_d  = out_sel_q;
      if (in_xfer) begin
         out_val_d  = 1'b1;
         out_data_d = gnt_data;
         out_sel_d  = gnt_idx;
         if (ARB_MODE == ARB_RR) begin
            ptr_d = (gnt_idx == SELBITS'(NINPUTS-1)) ? '0 : gnt_idx + SELBITS'(1);
         end
      end else if (out_xfer) begin
         out_val_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q      <= '0;
         out_val_q  <= 1'b0;
         out_data_q <= '0;
         out_sel_q  <= '0;
      end else begin
         ptr_q      <= ptr_d;
         out_val_q  <= out_val_d;
         out_data_q <= out_data_d;
         out_sel_q  <= out_sel_d;
      end
   end

   assign bus.out_val  = out_val_q;
   assign bus.out_data = out_data_q;
   assign bus.out_sel  = out_sel_q;

endmodule

// File: tb/tb_mux_arb_nb_rtl.sv
// Bench for the arbitrated mux: round-robin, fixed-priority and 3-input wrap instances.
module tb_mux_arb_nb_rtl;
   import mux_arb_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   mux_arb_nb_rtl_if #(.NBITS(4), .NINPUTS(4)) bus_rr();
   mux_arb_nb_rtl_if #(.NBITS(4), .NINPUTS(4)) bus_fx();
   mux_arb_nb_rtl_if #(.NBITS(4), .NINPUTS(3)) bus_n3();

   mux_arb_nb_rtl #(.NBITS(4), .NINPUTS(4), .ARB_MODE(ARB_RR))
      dut_rr (.clk(clk), .rst_n(rst_n), .bus(bus_rr));
   mux_arb_nb_rtl #(.NBITS(4), .NINPUTS(4), .ARB_MODE(ARB_FIXED))
      dut_fx (.clk(clk), .rst_n(rst_n), .bus(bus_fx));
   mux_arb_nb_rtl #(.NBITS(4), .NINPUTS(3), .ARB_MODE(ARB_RR))
      dut_n3 (.clk(clk), .rst_n(rst_n), .bus(bus_n3));

   typedef struct {
      logic [3:0]  val;
      logic [15:0] dat;
      logic        ordy;
      logic [3:0]  e_rdy;
      logic        e_val;
      logic [3:0]  e_dat;
      logic [1:0]  e_sel;
   } vec_t;

   vec_t vecs[14];

   function automatic vec_t mk(input logic [3:0] val, input logic [15:0] dat, input logic ordy,
                               input logic [3:0] e_rdy, input logic e_val,
                               input logic [3:0] e_dat, input logic [1:0] e_sel);
      vec_t v;
      v.val = val; v.dat = dat; v.ordy = ordy;
      v.e_rdy = e_rdy; v.e_val = e_val; v.e_dat = e_dat; v.e_sel = e_sel;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      bus_rr.in_val = '0; bus_rr.in_data = '0; bus_rr.out_rdy = 1'b0;
      bus_fx.in_val = '0; bus_fx.in_data = '0; bus_fx.out_rdy = 1'b0;
      bus_n3.in_val = '0; bus_n3.in_data = '0; bus_n3.out_rdy = 1'b0;
   endtask

   task automatic step_n3(input string name, input logic [2:0] val, input logic [2:0] e_rdy,
                          input logic [3:0] e_dat, input logic [1:0] e_sel);
      bus_n3.in_val  = val;
      bus_n3.in_data = 12'h321;
      bus_n3.out_rdy = 1'b1;
      #1;
      check({name, " n3 in_rdy"}, 32'(bus_n3.in_rdy), 32'(e_rdy));
      tick();
      check({name, " n3 out_val"}, 32'(bus_n3.out_val), 32'd1);
      check({name, " n3 out_data"}, 32'(bus_n3.out_data), 32'(e_dat));
      check({name, " n3 out_sel"}, 32'(bus_n3.out_sel), 32'(e_sel));
      check({name, " n3 out_sel<3"}, 32'(bus_n3.out_sel < 2'd3), 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0]  = mk(4'b0100, 16'h0A00, 1'b1, 4'b0100, 1'b1, 4'hA, 2'd2);
      vecs[1]  = mk(4'b1000, 16'h7000, 1'b1, 4'b1000, 1'b1, 4'h7, 2'd3);
      vecs[2]  = mk(4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
      vecs[3]  = mk(4'b1111, 16'h4321, 1'b1, 4'b0010, 1'b1, 4'h2, 2'd1);
      vecs[4]  = mk(4'b1111, 16'h4321, 1'b1, 4'b0100, 1'b1, 4'h3, 2'd2);
      vecs[5]  = mk(4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
      vecs[6]  = mk(4'b1111, 16'h4321, 1'b1, 4'b0001, 1'b1, 4'h1, 2'd0);
      vecs[7]  = mk(4'b0100, 16'h0500, 1'b1, 4'b0100, 1'b1, 4'h5, 2'd2);
      vecs[8]  = mk(4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
      vecs[9]  = mk(4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
      vecs[10] = mk(4'b1111, 16'h4321, 1'b0, 4'b0000, 1'b1, 4'h5, 2'd2);
      vecs[11] = mk(4'b1111, 16'h4321, 1'b1, 4'b1000, 1'b1, 4'h4, 2'd3);
      vecs[12] = mk(4'b0000, 16'h0000, 1'b0, 4'b0000, 1'b1, 4'h4, 2'd3);
      vecs[13] = mk(4'b0000, 16'h0000, 1'b1, 4'b0000, 1'b0, 4'h4, 2'd3);

      // Reset held with random inputs: outputs cleared and no ready raised.
      rst_n = 1'b0;
      idle_all();
      for (int r = 0; r < 3; r++) begin
         bus_rr.in_val = 4'($urandom); bus_rr.in_data = 16'($urandom); bus_rr.out_rdy = 1'($urandom);
         bus_fx.in_val = 4'($urandom); bus_fx.in_data = 16'($urandom); bus_fx.out_rdy = 1'($urandom);
         bus_n3.in_val = 3'($urandom); bus_n3.in_data = 12'($urandom); bus_n3.out_rdy = 1'($urandom);
         tick();
         check("reset rr out_val", 32'(bus_rr.out_val), 32'd0);
         check("reset rr out_data", 32'(bus_rr.out_data), 32'd0);
         check("reset rr out_sel", 32'(bus_rr.out_sel), 32'd0);
         check("reset rr in_rdy", 32'(bus_rr.in_rdy), 32'd0);
         check("reset fx in_rdy", 32'(bus_fx.in_rdy), 32'd0);
         check("reset n3 in_rdy", 32'(bus_n3.in_rdy), 32'd0);
      end
      idle_all();
      tick();
      rst_n = 1'b1;

      // Round-robin instance: single channel, fairness, backpressure, drain+refill.
      for (int i = 0; i < 14; i++) begin
         bus_rr.in_val  = vecs[i].val;
         bus_rr.in_data = vecs[i].dat;
         bus_rr.out_rdy = vecs[i].ordy;
         #1;
         check($sformatf("vec%0d in_rdy", i), 32'(bus_rr.in_rdy), 32'(vecs[i].e_rdy));
         tick();
         check($sformatf("vec%0d out_val", i), 32'(bus_rr.out_val), 32'(vecs[i].e_val));
         check($sformatf("vec%0d out_data", i), 32'(bus_rr.out_data), 32'(vecs[i].e_dat));
         check($sformatf("vec%0d out_sel", i), 32'(bus_rr.out_sel), 32'(vecs[i].e_sel));
      end
      bus_rr.in_val = '0; bus_rr.out_rdy = 1'b0;

      // Fixed priority: channel 1 always beats channel 3.
      for (int c = 0; c < 3; c++) begin
         bus_fx.in_val = 4'b1010; bus_fx.in_data = 16'h4321; bus_fx.out_rdy = 1'b1;
         #1;
         check($sformatf("fixed%0d in_rdy", c), 32'(bus_fx.in_rdy), 32'b0010);
         tick();
         check($sformatf("fixed%0d out_val", c), 32'(bus_fx.out_val), 32'd1);
         check($sformatf("fixed%0d out_sel", c), 32'(bus_fx.out_sel), 32'd1);
         check($sformatf("fixed%0d out_data", c), 32'(bus_fx.out_data), 32'h2);
      end
      bus_fx.in_val = 4'b1000;
      #1;
      check("fixed ch3 alone in_rdy", 32'(bus_fx.in_rdy), 32'b1000);
      tick();
      check("fixed ch3 alone out_sel", 32'(bus_fx.out_sel), 32'd3);
      check("fixed ch3 alone out_data", 32'(bus_fx.out_data), 32'h4);
      bus_fx.in_val = '0; bus_fx.out_rdy = 1'b0;

      // Three inputs: pointer wraps from 2 to 0 and grants stay below 3.
      step_n3("setptr2", 3'b010, 3'b010, 4'h2, 2'd1);
      step_n3("wrap",    3'b011, 3'b001, 4'h1, 2'd0);
      step_n3("ptr1",    3'b011, 3'b010, 4'h2, 2'd1);
      step_n3("all2",    3'b111, 3'b100, 4'h3, 2'd2);
      step_n3("all0",    3'b111, 3'b001, 4'h1, 2'd0);
      step_n3("all1",    3'b111, 3'b010, 4'h2, 2'd1);
      step_n3("all2b",   3'b111, 3'b100, 4'h3, 2'd2);
      bus_n3.in_val = '0; bus_n3.out_rdy = 1'b0;

      // Asynchronous reset while the buffer holds an entry.
      bus_rr.in_val = 4'b0001; bus_rr.in_data = 16'h0009; bus_rr.out_rdy = 1'b0;
      tick();
      check("prearst out_val", 32'(bus_rr.out_val), 32'd1);
      check("prearst out_data", 32'(bus_rr.out_data), 32'h9);
      rst_n = 1'b0;
      #1;
      check("arst out_val", 32'(bus_rr.out_val), 32'd0);
      check("arst out_data", 32'(bus_rr.out_data), 32'd0);
      check("arst out_sel", 32'(bus_rr.out_sel), 32'd0);
      check("arst in_rdy", 32'(bus_rr.in_rdy), 32'd0);
      idle_all();
      tick();
      rst_n = 1'b1;
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
